axis_frame_limit: RTL and testbench

Frame-length policing stage placed directly upstream of the AXI4-Stream frame FIFO. Counts beats per input frame, truncates frames longer than a runtime maximum by forcing `tlast`, and discards the rest of the frame. Flags truncated and runt frames with the bad-frame `tuser` value, so the downstream FIFO with `DROP_BAD_FRAME=1` discards them. Provides one registered output stage.

---
 rtl/axis_frame_limit_pkg.sv | 12 +
 rtl/axis_frame_limit_reg.sv | 37 +++
 rtl/axis_frame_limit.sv | 188 ++++++++++++++++++
 tb/tb_axis_frame_limit.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_frame_limit_pkg.sv
// Shared types and constants for the AXI4-Stream frame-length policing stage.
package axis_frame_limit_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPass,
    StDrop
  } state_e;

  localparam int unsigned CntWidth = 32;

endpackage

// File: rtl/axis_frame_limit_reg.sv
// Single registered AXI4-Stream stage with valid/ready and a packed payload.
// Only the valid bit is reset; the payload register carries no reset.
module axis_frame_limit_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign in_ready  = out_ready || !valid_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      data_q <= in_data;
    end
  end

endmodule

// File: rtl/axis_frame_limit.sv
// Frame-length policing stage: truncates over-long frames and flags runts via tuser.
// Define AXIS_FRAME_LIMIT_CNT_EN to add the 32-bit good/truncated/short frame counters.
module axis_frame_limit
  import axis_frame_limit_pkg::*;
#(
  parameter int                    DATA_WIDTH           = 8,
  parameter bit                    KEEP_ENABLE          = (DATA_WIDTH > 8),
  parameter int                    KEEP_WIDTH           = (DATA_WIDTH + 7) / 8,
  parameter int                    ID_WIDTH             = 8,
  parameter int                    DEST_WIDTH           = 8,
  parameter int                    USER_WIDTH           = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter int                    LEN_WIDTH            = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LEN_WIDTH-1:0]  max_beats,
  input  logic [LEN_WIDTH-1:0]  min_beats,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
`ifdef AXIS_FRAME_LIMIT_CNT_EN
  output logic [CntWidth-1:0]   count_good,
  output logic [CntWidth-1:0]   count_truncated,
  output logic [CntWidth-1:0]   count_short,
`endif
  output logic                  status_truncated,
  output logic                  status_short,
  output logic [LEN_WIDTH-1:0]  frame_len
);

  localparam int PayloadWidth = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]    max_l_q, max_l_d;
  logic [LEN_WIDTH-1:0]    min_l_q, min_l_d;
  logic [LEN_WIDTH-1:0]    frame_len_q, frame_len_d;
  logic                    trunc_q, short_q;

  logic                    out_rdy;
  logic                    fwd_valid;
  logic                    fwd_last;
  logic [USER_WIDTH-1:0]   fwd_user;
  logic [KEEP_WIDTH-1:0]   keep_in;
  logic                    trunc_ev, short_ev, good_ev;
  logic [LEN_WIDTH-1:0]    cnt_cur, max_eff, min_eff;
  logic [PayloadWidth-1:0] pay_in, pay_out;

  assign keep_in = KEEP_ENABLE ? s_axis_tkeep : '1;

  // The first beat of a frame uses the live limits, which are latched in the same cycle.
  assign max_eff = (state_q == StIdle) ? max_beats : max_l_q;
  assign min_eff = (state_q == StIdle) ? min_beats : min_l_q;
  assign cnt_cur = (state_q == StIdle) ? LEN_WIDTH'(1) :
                   (&cnt_q)            ? cnt_q : cnt_q + LEN_WIDTH'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    max_l_d       = max_l_q;
    min_l_d       = min_l_q;
    frame_len_d   = frame_len_q;
    s_axis_tready = out_rdy;
    fwd_valid     = 1'b0;
    fwd_last      = s_axis_tlast;
    fwd_user      = s_axis_tuser;
    trunc_ev      = 1'b0;
    short_ev      = 1'b0;
    good_ev       = 1'b0;
    case (state_q)
      StIdle, StPass: begin
        fwd_valid = s_axis_tvalid;
        if (s_axis_tvalid && out_rdy) begin
          if (state_q == StIdle) begin
            max_l_d = max_beats;
            min_l_d = min_beats;
          end
          cnt_d = cnt_cur;
          if ((max_eff != '0) && (cnt_cur == max_eff) && !s_axis_tlast) begin
            fwd_last = 1'b1;
            fwd_user = USER_BAD_FRAME_VALUE;
            trunc_ev = 1'b1;
            state_d  = StDrop;
          end else if (s_axis_tlast) begin
            frame_len_d = cnt_cur;
            state_d     = StIdle;
            if ((min_eff != '0) && (cnt_cur < min_eff)) begin
              fwd_user = USER_BAD_FRAME_VALUE;
              short_ev = 1'b1;
            end else begin
              good_ev = 1'b1;
            end
          end else begin
            state_d = StPass;
          end
        end
      end
      StDrop: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          cnt_d = cnt_cur;
          if (s_axis_tlast) begin
            frame_len_d = cnt_cur;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      max_l_q     <= '0;
      min_l_q     <= '0;
      frame_len_q <= '0;
      trunc_q     <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_l_q     <= max_l_d;
      min_l_q     <= min_l_d;
      frame_len_q <= frame_len_d;
      trunc_q     <= trunc_ev;
      short_q     <= short_ev;
    end
  end

  assign status_truncated = trunc_q;
  assign status_short     = short_q;
  assign frame_len        = frame_len_q;

`ifdef AXIS_FRAME_LIMIT_CNT_EN
  logic [CntWidth-1:0] good_q, trc_q, sht_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_q <= '0;
      trc_q  <= '0;
      sht_q  <= '0;
    end else begin
      if (good_ev)  good_q <= good_q + CntWidth'(1);
      if (trunc_ev) trc_q  <= trc_q + CntWidth'(1);
      if (short_ev) sht_q  <= sht_q + CntWidth'(1);
    end
  end

  assign count_good      = good_q;
  assign count_truncated = trc_q;
  assign count_short     = sht_q;
`endif

  assign pay_in = {s_axis_tdata, keep_in, fwd_last, s_axis_tid, s_axis_tdest, fwd_user};

  axis_frame_limit_reg #(
    .WIDTH(PayloadWidth)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (fwd_valid),
    .in_ready (out_rdy),
    .in_data  (pay_in),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready),
    .out_data (pay_out)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} =
    pay_out;

endmodule

// File: tb/tb_axis_frame_limit.sv
// Directed self-checking bench for axis_frame_limit (default build, 8-bit data).
module tb_axis_frame_limit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] max_beats, min_beats;
  logic [7:0]  s_tdata;
  logic [0:0]  s_tkeep;
  logic        s_tvalid, s_tready, s_tlast;
  logic [7:0]  s_tid, s_tdest;
  logic [0:0]  s_tuser;
  logic [7:0]  m_tdata;
  logic [0:0]  m_tkeep;
  logic        m_tvalid, m_tready, m_tlast;
  logic [7:0]  m_tid, m_tdest;
  logic [0:0]  m_tuser;
  logic        st_trunc, st_short;
  logic [15:0] frame_len;

  int total = 0;
  int bad   = 0;
  int n_trunc = 0;
  int n_short = 0;
  logic [7:0] q_data[$];
  logic       q_last[$];
  logic       q_user[$];

  always #5 clk = ~clk;

  axis_frame_limit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .max_beats       (max_beats),
    .min_beats       (min_beats),
    .s_axis_tdata    (s_tdata),
    .s_axis_tkeep    (s_tkeep),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tready   (s_tready),
    .s_axis_tlast    (s_tlast),
    .s_axis_tid      (s_tid),
    .s_axis_tdest    (s_tdest),
    .s_axis_tuser    (s_tuser),
    .m_axis_tdata    (m_tdata),
    .m_axis_tkeep    (m_tkeep),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tready   (m_tready),
    .m_axis_tlast    (m_tlast),
    .m_axis_tid      (m_tid),
    .m_axis_tdest    (m_tdest),
    .m_axis_tuser    (m_tuser),
    .status_truncated(st_trunc),
    .status_short    (st_short),
    .frame_len       (frame_len)
  );

  // Output monitor: a handshake visible at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_tvalid && m_tready) begin
        q_data.push_back(m_tdata);
        q_last.push_back(m_tlast);
        q_user.push_back(m_tuser[0]);
      end
      if (st_trunc) n_trunc++;
      if (st_short) n_short++;
    end
  end

  task automatic clear_mon();
    q_data.delete();
    q_last.delete();
    q_user.delete();
    n_trunc = 0;
    n_short = 0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    bit ok = 0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (s_tready === 1'b1);
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_beat timeout data=%h got ready=%b want ready=1", d, s_tready);
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) send_beat(base + 8'(i), (i == n - 1));
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++; $display("FAIL reset_tvalid got=%b want=0", m_tvalid);
    end
    total++;
    if (frame_len !== 16'd0) begin
      bad++; $display("FAIL reset_frame_len got=%0d want=0", frame_len);
    end
    total++;
    if (st_trunc !== 1'b0 || st_short !== 1'b0) begin
      bad++; $display("FAIL reset_status got=%b%b want=00", st_trunc, st_short);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pass();
    logic [7:0] ed[3] = '{8'h10, 8'h11, 8'h12};
    logic       el[3] = '{1'b0, 1'b0, 1'b1};
    clear_mon();
    max_beats = 16'd4; min_beats = 16'd0;
    send_frame(8'h10, 3);
    settle();
    total++;
    if (q_data.size() !== 3) begin
      bad++; $display("FAIL pass_count got=%0d want=3", q_data.size());
    end
    for (int i = 0; i < 3 && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== ed[i] || q_last[i] !== el[i] || q_user[i] !== 1'b0) begin
        bad++;
        $display("FAIL pass_beat%0d got d=%h l=%b u=%b want d=%h l=%b u=0",
                 i, q_data[i], q_last[i], q_user[i], ed[i], el[i]);
      end
    end
    total++;
    if (frame_len !== 16'd3 || n_trunc != 0 || n_short != 0) begin
      bad++;
      $display("FAIL pass_status got len=%0d tr=%0d sh=%0d want len=3 tr=0 sh=0",
               frame_len, n_trunc, n_short);
    end
  endtask

  task automatic test_truncate();
    logic [7:0] ed[4] = '{8'h20, 8'h21, 8'h22, 8'h23};
    logic       el[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    clear_mon();
    max_beats = 16'd4; min_beats = 16'd0;
    for (int i = 0; i < 4; i++) send_beat(8'h20 + 8'(i), 1'b0);
    // Stall the output: dropped beats must still be accepted.
    m_tready = 1'b0;
    for (int i = 4; i < 7; i++) begin
      s_tdata = 8'h20 + 8'(i);
      s_tlast = (i == 6);
      @(negedge clk);
      total++;
      if (s_tready !== 1'b1) begin
        bad++; $display("FAIL trunc_drop_ready beat%0d got=%b want=1", i + 1, s_tready);
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1;
    settle();
    total++;
    if (q_data.size() !== 4) begin
      bad++; $display("FAIL trunc_count got=%0d want=4", q_data.size());
    end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== ed[i] || q_last[i] !== el[i] || q_user[i] !== el[i]) begin
        bad++;
        $display("FAIL trunc_beat%0d got d=%h l=%b u=%b want d=%h l=%b u=%b",
                 i, q_data[i], q_last[i], q_user[i], ed[i], el[i], el[i]);
      end
    end
    total++;
    if (frame_len !== 16'd7 || n_trunc != 1 || n_short != 0) begin
      bad++;
      $display("FAIL trunc_status got len=%0d tr=%0d sh=%0d want len=7 tr=1 sh=0",
               frame_len, n_trunc, n_short);
    end
  endtask

  task automatic test_short();
    clear_mon();
    max_beats = 16'd0; min_beats = 16'd3;
    send_frame(8'h30, 2);
    settle();
    total++;
    if (q_data.size() !== 2) begin
      bad++; $display("FAIL short_count got=%0d want=2", q_data.size());
    end else begin
      total++;
      if (q_data[0] !== 8'h30 || q_last[0] !== 1'b0 || q_user[0] !== 1'b0 ||
          q_data[1] !== 8'h31 || q_last[1] !== 1'b1 || q_user[1] !== 1'b1) begin
        bad++;
        $display("FAIL short_beats got %h/%b/%b %h/%b/%b want 30/0/0 31/1/1", q_data[0],
                 q_last[0], q_user[0], q_data[1], q_last[1], q_user[1]);
      end
    end
    total++;
    if (frame_len !== 16'd2 || n_trunc != 0 || n_short != 1) begin
      bad++;
      $display("FAIL short_status got len=%0d tr=%0d sh=%0d want len=2 tr=0 sh=1",
               frame_len, n_trunc, n_short);
    end
  endtask

  task automatic test_exact();
    clear_mon();
    max_beats = 16'd4; min_beats = 16'd0;
    send_frame(8'h40, 4);
    settle();
    total++;
    if (q_data.size() !== 4) begin
      bad++; $display("FAIL exact_count got=%0d want=4", q_data.size());
    end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== 8'h40 + 8'(i) || q_last[i] !== (i == 3) || q_user[i] !== 1'b0) begin
        bad++;
        $display("FAIL exact_beat%0d got d=%h l=%b u=%b want d=%h l=%b u=0",
                 i, q_data[i], q_last[i], q_user[i], 8'h40 + 8'(i), (i == 3));
      end
    end
    total++;
    if (frame_len !== 16'd4 || n_trunc != 0 || n_short != 0) begin
      bad++;
      $display("FAIL exact_status got len=%0d tr=%0d sh=%0d want len=4 tr=0 sh=0",
               frame_len, n_trunc, n_short);
    end
  endtask

  task automatic test_priority();
    clear_mon();
    max_beats = 16'd2; min_beats = 16'd5;
    send_frame(8'h70, 4);
    settle();
    total++;
    if (q_data.size() !== 2 || n_trunc != 1 || n_short != 0 || frame_len !== 16'd4) begin
      bad++;
      $display("FAIL prio_status got n=%0d tr=%0d sh=%0d len=%0d want n=2 tr=1 sh=0 len=4",
               q_data.size(), n_trunc, n_short, frame_len);
    end else begin
      total++;
      if (q_data[1] !== 8'h71 || q_last[1] !== 1'b1 || q_user[1] !== 1'b1) begin
        bad++;
        $display("FAIL prio_last got %h/%b/%b want 71/1/1", q_data[1], q_last[1], q_user[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    bool_t_dummy: begin end
    clear_mon();
    max_beats = 16'd0; min_beats = 16'd0;
    fork
      send_frame(8'h50, 6);
      begin
        for (int i = 0; i < 100 && q_data.size() < 2; i++) @(negedge clk);
        @(posedge clk); #1;
        m_tready = 1'b0;
        @(negedge clk);
        held = m_tdata;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          total++;
          if (m_tvalid !== 1'b1 || m_tdata !== held || s_tready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cyc%0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                     i, m_tvalid, m_tdata, s_tready, held);
          end
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
      end
    join
    settle();
    total++;
    if (q_data.size() !== 6) begin
      bad++; $display("FAIL bp_count got=%0d want=6", q_data.size());
    end
    for (int i = 0; i < 6 && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== 8'h50 + 8'(i) || q_last[i] !== (i == 5)) begin
        bad++;
        $display("FAIL bp_beat%0d got d=%h l=%b want d=%h l=%b",
                 i, q_data[i], q_last[i], 8'h50 + 8'(i), (i == 5));
      end
    end
  endtask

  task automatic test_reset_mid();
    max_beats = 16'd3; min_beats = 16'd0;
    send_beat(8'h5a, 1'b0);
    send_beat(8'h5b, 1'b0);
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (m_tvalid !== 1'b0 || frame_len !== 16'd0) begin
      bad++;
      $display("FAIL rstmid_state got v=%b len=%0d want v=0 len=0", m_tvalid, frame_len);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    // With max=3 a counter that failed to restart would truncate the first beat.
    send_frame(8'h60, 2);
    settle();
    total++;
    if (q_data.size() !== 2 || n_trunc != 0 || frame_len !== 16'd2) begin
      bad++;
      $display("FAIL rstmid_frame got n=%0d tr=%0d len=%0d want n=2 tr=0 len=2",
               q_data.size(), n_trunc, frame_len);
    end else begin
      total++;
      if (q_data[0] !== 8'h60 || q_last[0] !== 1'b0 || q_user[0] !== 1'b0 ||
          q_data[1] !== 8'h61 || q_last[1] !== 1'b1 || q_user[1] !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_beats got %h/%b/%b %h/%b/%b want 60/0/0 61/1/0", q_data[0],
                 q_last[0], q_user[0], q_data[1], q_last[1], q_user[1]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    max_beats = '0; min_beats = '0;
    s_tdata = '0; s_tkeep = '1; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tid = '0; s_tdest = '0; s_tuser = '0;
    m_tready = 1'b1;
    test_reset();
    test_pass();
    test_truncate();
    test_short();
    test_exact();
    test_priority();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
